coil_scheduler: RTL and testbench
=================================

// Module: coil_scheduler
// PURPOSE
//   Angle-based multi-channel coil (dwell/fire) scheduler driven by the crank sync decoder.
//   Consumes eng_phase/synced from sync; per channel turns coil_out on when phase crosses the
//   start angle and off (spark) when phase crosses the end angle. Hard dwell-time limit per
//   channel. Runtime-reconfigurable through a single-cycle write port.
// PARAMETERS
//   N_CH          4      number of coil channels (1..16)
//   PHASE_MAX     7200   phase units per engine cycle (0.1 deg over 720 deg); valid phase 0..PHASE_MAX-1
//   DWELL_MAX_CYC 20000  max clk cycles coil may stay on before forced off + fault
//   TMR_W         24     dwell timer width; DWELL_MAX_CYC < 2**TMR_W
// PORTS
//   clk        in   1              system clock
//   rst_n      in   1              synchronous reset, active low
//   eng_phase  in   16             current engine phase from sync (units per PHASE_MAX)
//   synced     in   1              sync decoder locked; eng_phase valid only when 1
//   cfg_we     in   1              config write strobe (one cycle)
//   cfg_ch     in   $clog2(N_CH)   channel index for write
//   cfg_en     in   1              channel enable value
//   cfg_start  in   16             dwell start angle
//   cfg_end    in   16             fire (end) angle
//   cfg_err    out  1              1-cycle pulse: write rejected
//   coil_out   out  N_CH           coil drive, 1 = dwelling (registered)
//   fault      out  N_CH           sticky dwell-timeout flag per channel
// BEHAVIOUR
//   Clock/reset: single clock clk; rst_n synchronous, active low. Reset: coil_out=0, fault=0,
//     cfg_err=0, all channels OFF, en=0, start=end=0, timers=0, prev_valid=0.
//   Crossing detect: prev_phase register + prev_valid. Angle A crossed in a cycle iff synced,
//     prev_valid, and cur!=prev and: (prev<cur and prev<A<=cur) or (cur<prev, wrap, and
//     (A>prev or A<=cur)). cur==prev -> nothing crossed. Skipped phase values still detected.
//   prev_valid: set on every synced cycle (prev_phase<=eng_phase); cleared when synced=0. First
//     synced cycle only seeds prev_phase, no crossings evaluated.
//   Per-channel FSM: OFF, WAIT, DWELL.
//     OFF:   coil 0; en=1 (via write) -> WAIT.
//     WAIT:  coil 0; start crossed and end not crossed same cycle -> DWELL, timer=0.
//            start and end crossed same cycle -> stay WAIT (no spark). End-only crossing ignored.
//     DWELL: coil 1; timer++ per cycle; end crossed (regardless of start) -> WAIT, coil 0;
//            timer reaches DWELL_MAX_CYC-1 -> WAIT, coil 0, fault[ch]=1.
//   Latency: coil_out changes on the clk edge after the cycle in which eng_phase presents the
//     crossing (1 cycle). Coil on-time in DWELL never exceeds DWELL_MAX_CYC cycles.
//   synced=0 in any cycle: all coil_out 0 next edge; enabled channels -> WAIT; timers cleared.
//   Config write (cfg_we=1): rejected if cfg_ch>=N_CH, cfg_start>=PHASE_MAX or
//     cfg_end>=PHASE_MAX -> cfg_err=1 next cycle, no state change. Accepted: next edge loads
//     start/end/en for cfg_ch, clears fault[cfg_ch]; cfg_en=0 -> OFF, cfg_en=1 -> WAIT (an active
//     dwell is aborted, coil 0). New angles used from the following cycle's crossing check.
//   start==end: both always cross together -> channel never dwells (effectively disabled).
//   Channels independent; any number may dwell simultaneously. Reset mid-dwell: coil 0 next edge.
// TESTING
//   1. ch0 en, start=100, end=400; phase steps 0,60,...,420 (synced) -> coil_out[0] rises edge
//      after phase=120, falls edge after phase=420; fault=0.
//   2. Wrap: ch1 start=7000, end=200; phase 6960->7020->...->7140->0->60->...->240 ->
//      coil_out[1] on after 7020, stays on across 0, off after 240.
//   3. Timeout: DWELL_MAX_CYC=50, start crossed, end never reached -> coil on exactly 50 cycles,
//      then 0, fault[ch]=1; fault clears on next write to that channel.
//   4. synced drops mid-dwell -> coil 0 next edge; synced returns at phase=300 (between start
//      and end) -> no dwell until start crossed in next engine cycle.
//   5. Phase jump 50->500 with start=100, end=400 -> no dwell; cfg_start=7200 write -> cfg_err
//      pulse, config unchanged.
//   6. Rewrite channel during DWELL with cfg_en=1 -> coil 0 next edge, new angles honoured in
//      next cycle; rst_n=0 mid-dwell -> all outputs 0 next edge.

Source files
------------

// File: rtl/coil_scheduler.sv
// Angle-based multi-channel coil dwell/fire scheduler. Each channel starts dwelling when the
// crank phase passes its start angle and fires when it passes its end angle.
module coil_scheduler #(
    parameter  int N_CH          = 4,
    parameter  int PHASE_MAX     = 7200,
    parameter  int DWELL_MAX_CYC = 20000,
    parameter  int TMR_W         = 24,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     eng_phase,
    input  logic            synced,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic            cfg_en,
    input  logic [15:0]     cfg_start,
    input  logic [15:0]     cfg_end,
    output logic            cfg_err,
    output logic [N_CH-1:0] coil_out,
    output logic [N_CH-1:0] fault
);

    typedef enum logic [1:0] {
        CH_OFF   = 2'd0,
        CH_WAIT  = 2'd1,
        CH_DWELL = 2'd2
    } ch_state_e;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DWELL_MAX_CYC - 1);

    // True when the phase moved from prv to cur and swept over ang; a wrap through zero counts.
    function automatic logic angle_crossed(
        input logic [15:0] prv,
        input logic [15:0] cur,
        input logic [15:0] ang
    );
        logic hit;
        if (prv < cur) begin
            hit = (ang > prv) && (ang <= cur);
        end else if (cur < prv) begin
            hit = (ang > prv) || (ang <= cur);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    function automatic logic cfg_legal(
        input logic [CH_W-1:0] ch,
        input logic [15:0]     st,
        input logic [15:0]     nd
    );
        return (32'(ch) < N_CH) && (32'(st) < PHASE_MAX) && (32'(nd) < PHASE_MAX);
    endfunction

    logic [15:0]      prev_phase_r;
    logic             prev_valid_r;
    logic             cfg_err_r;
    logic [N_CH-1:0]  coil_r;
    logic [N_CH-1:0]  fault_r;
    ch_state_e        state_r [N_CH];
    logic [15:0]      start_r [N_CH];
    logic [15:0]      end_r   [N_CH];
    logic [TMR_W-1:0] timer_r [N_CH];

    logic             eval_s;
    logic             cfg_ok_s;
    logic [N_CH-1:0]  start_x_s;
    logic [N_CH-1:0]  end_x_s;

    // Write qualification and crossing evaluation against the angles currently in force.
    always_comb begin
        eval_s    = synced && prev_valid_r;
        cfg_ok_s  = cfg_we && cfg_legal(cfg_ch, cfg_start, cfg_end);
        start_x_s = '0;
        end_x_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (eval_s) begin
                start_x_s[i] = angle_crossed(prev_phase_r, eng_phase, start_r[i]);
                end_x_s[i]   = angle_crossed(prev_phase_r, eng_phase, end_r[i]);
            end else begin
                start_x_s[i] = 1'b0;
                end_x_s[i]   = 1'b0;
            end
        end
    end

    // Phase history, config port and per-channel dwell state machines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_phase_r <= 16'd0;
            prev_valid_r <= 1'b0;
            cfg_err_r    <= 1'b0;
            coil_r       <= '0;
            fault_r      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= CH_OFF;
                start_r[i] <= 16'd0;
                end_r[i]   <= 16'd0;
                timer_r[i] <= '0;
            end
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok_s;
            if (synced) begin
                prev_phase_r <= eng_phase;
                prev_valid_r <= 1'b1;
            end else begin
                prev_phase_r <= prev_phase_r;
                prev_valid_r <= 1'b0;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_ok_s && (32'(cfg_ch) == i)) begin
                    // A write always aborts any dwell in progress on that channel.
                    start_r[i] <= cfg_start;
                    end_r[i]   <= cfg_end;
                    state_r[i] <= cfg_en ? CH_WAIT : CH_OFF;
                    fault_r[i] <= 1'b0;
                    coil_r[i]  <= 1'b0;
                    timer_r[i] <= '0;
                end else if (!synced) begin
                    state_r[i] <= (state_r[i] == CH_OFF) ? CH_OFF : CH_WAIT;
                    coil_r[i]  <= 1'b0;
                    timer_r[i] <= '0;
                end else begin
                    case (state_r[i])
                        CH_OFF: begin
                            coil_r[i]  <= 1'b0;
                            timer_r[i] <= '0;
                        end
                        CH_WAIT: begin
                            timer_r[i] <= '0;
                            if (start_x_s[i] && !end_x_s[i]) begin
                                state_r[i] <= CH_DWELL;
                                coil_r[i]  <= 1'b1;
                            end else begin
                                coil_r[i]  <= 1'b0;
                            end
                        end
                        CH_DWELL: begin
                            if (end_x_s[i]) begin
                                state_r[i] <= CH_WAIT;
                                coil_r[i]  <= 1'b0;
                                timer_r[i] <= '0;
                            end else if (timer_r[i] == TMR_LAST) begin
                                state_r[i] <= CH_WAIT;
                                coil_r[i]  <= 1'b0;
                                fault_r[i] <= 1'b1;
                                timer_r[i] <= '0;
                            end else begin
                                coil_r[i]  <= 1'b1;
                                timer_r[i] <= timer_r[i] + TMR_W'(1);
                            end
                        end
                        default: begin
                            state_r[i] <= CH_OFF;
                            coil_r[i]  <= 1'b0;
                            timer_r[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign cfg_err  = cfg_err_r;
    assign coil_out = coil_r;
    assign fault    = fault_r;

endmodule

// File: tb/tb_coil_scheduler.sv
// Self-checking bench for coil_scheduler: directed vector table, hand-written corner sequences
// and a randomized run compared against a phase-distance reference model.
module tb_coil_scheduler;

    localparam int N_CH = 4;
    localparam int PM   = 7200;
    localparam int DMAX = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] eng_phase = 16'd0;
    logic        synced = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_start = 16'd0;
    logic [15:0] cfg_end = 16'd0;
    logic        cfg_err;
    logic [3:0]  coil_out;
    logic [3:0]  fault;

    int n_checks = 0;
    int n_fail   = 0;

    coil_scheduler #(.N_CH(N_CH), .PHASE_MAX(PM), .DWELL_MAX_CYC(DMAX), .TMR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .eng_phase(eng_phase), .synced(synced),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_start(cfg_start),
        .cfg_end(cfg_end), .cfg_err(cfg_err), .coil_out(coil_out), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = off, 1 = armed, 2 = coil on; cnt = cycles the coil has been on.
    int       m_mode  [N_CH];
    int       m_start [N_CH];
    int       m_end   [N_CH];
    int       m_cnt   [N_CH];
    logic [3:0] m_coil, m_fault;
    logic     m_err;
    int       m_prev;
    bit       m_pv;

    function automatic bit passes(int prv, int cur, int a);
        int mv, da;
        mv = (cur - prv + PM) % PM;
        da = (a - prv + PM) % PM;
        return (mv != 0) && (da > 0) && (da <= mv);
    endfunction

    task automatic model_update();
        bit valid, ok, sx, ex;
        int cur;
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                m_mode[c] = 0; m_start[c] = 0; m_end[c] = 0; m_cnt[c] = 0;
            end
            m_coil = 4'd0; m_fault = 4'd0; m_err = 1'b0; m_prev = 0; m_pv = 1'b0;
            return;
        end
        cur   = int'(eng_phase);
        valid = synced && m_pv;
        ok    = cfg_we && (int'(cfg_start) < PM) && (int'(cfg_end) < PM);
        m_err = cfg_we && !ok;
        for (int c = 0; c < N_CH; c++) begin
            sx = valid && passes(m_prev, cur, m_start[c]);
            ex = valid && passes(m_prev, cur, m_end[c]);
            if (ok && int'(cfg_ch) == c) begin
                m_start[c] = int'(cfg_start); m_end[c] = int'(cfg_end);
                m_mode[c] = cfg_en ? 1 : 0; m_fault[c] = 1'b0; m_coil[c] = 1'b0; m_cnt[c] = 0;
            end else if (!synced) begin
                if (m_mode[c] != 0) m_mode[c] = 1;
                m_coil[c] = 1'b0; m_cnt[c] = 0;
            end else if (m_mode[c] == 1) begin
                if (sx && !ex) begin
                    m_mode[c] = 2; m_coil[c] = 1'b1; m_cnt[c] = 1;
                end
            end else if (m_mode[c] == 2) begin
                if (ex) begin
                    m_mode[c] = 1; m_coil[c] = 1'b0;
                end else if (m_cnt[c] == DMAX) begin
                    m_mode[c] = 1; m_coil[c] = 1'b0; m_fault[c] = 1'b1;
                end else begin
                    m_cnt[c]++;
                end
            end
        end
        if (synced) begin
            m_prev = cur; m_pv = 1'b1;
        end else begin
            m_pv = 1'b0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wr(input int ch, input bit en, input int st, input int nd);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_en = en;
        cfg_start = 16'(st); cfg_end = 16'(nd);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic ph(input int p, input bit sy);
        eng_phase = 16'(p); synced = sy;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic        en;
        logic [15:0] st;
        logic [15:0] nd;
        logic [15:0] phs;
        logic        sy;
        logic [3:0]  ecoil;
        logic [3:0]  efault;
        logic        eerr;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] ch, logic en, int st, int nd, int phs,
                                logic sy, logic [3:0] ecoil, logic eerr);
        vec_t v;
        v.we = we; v.ch = ch; v.en = en; v.st = 16'(st); v.nd = 16'(nd);
        v.phs = 16'(phs); v.sy = sy; v.ecoil = ecoil; v.efault = 4'd0; v.eerr = eerr;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        int n, p, r;

        vt.push_back(mk(1'b1, 2'd0, 1'b1, 100, 400,   0, 1'b0, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0,   0, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0,  60, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 120, 1'b1, 4'b0001, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 180, 1'b1, 4'b0001, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 240, 1'b1, 4'b0001, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 300, 1'b1, 4'b0001, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 360, 1'b1, 4'b0001, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 420, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0,  50, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 500, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 560, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b1, 2'd0, 1'b1, 7200, 400, 560, 1'b1, 4'b0000, 1'b1));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 560, 1'b1, 4'b0000, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 150, 1'b1, 4'b0001, 1'b0));
        vt.push_back(mk(1'b0, 2'd0, 1'b0,   0,   0, 450, 1'b1, 4'b0000, 1'b0));

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("reset_coil", coil_out, 4'd0);
        check("reset_fault", fault, 4'd0);
        check("reset_err", cfg_err, 1'b0);
        rst_n = 1'b1;

        // Basic dwell, phase jump and rejected write
        foreach (vt[k]) begin
            cfg_we = vt[k].we; cfg_ch = vt[k].ch; cfg_en = vt[k].en;
            cfg_start = vt[k].st; cfg_end = vt[k].nd;
            eng_phase = vt[k].phs; synced = vt[k].sy;
            tick();
            check($sformatf("vec%0d_coil", k), coil_out, vt[k].ecoil);
            check($sformatf("vec%0d_fault", k), fault, vt[k].efault);
            check($sformatf("vec%0d_err", k), cfg_err, vt[k].eerr);
        end
        cfg_we = 1'b0;

        // Wrap-around dwell on ch1 with ch0 disabled
        synced = 1'b0;
        wr(1, 1'b1, 7000, 200);
        wr(0, 1'b0, 0, 0);
        ph(6960, 1'b1);
        check("wrap_seed", coil_out, 4'b0000);
        ph(7020, 1'b1);
        check("wrap_on", coil_out, 4'b0010);
        ph(7080, 1'b1); ph(7140, 1'b1); ph(0, 1'b1);
        check("wrap_across_zero", coil_out, 4'b0010);
        ph(60, 1'b1); ph(120, 1'b1); ph(180, 1'b1);
        check("wrap_before_end", coil_out, 4'b0010);
        ph(240, 1'b1);
        check("wrap_off", coil_out, 4'b0000);

        // Dwell timeout: phase held after start crossed
        ph(6990, 1'b1);
        ph(7010, 1'b1);
        n = 0;
        while (coil_out[1] && n < 200) begin
            n++;
            ph(7010, 1'b1);
        end
        check("timeout_len", n, DMAX);
        check("timeout_fault", fault, 4'b0010);
        wr(1, 1'b1, 100, 400);
        check("fault_clear", fault, 4'b0000);

        // Sync loss mid-dwell, resync between start and end
        ph(7100, 1'b1);
        ph(120, 1'b1);
        check("sync_dwell", coil_out, 4'b0010);
        ph(120, 1'b0);
        check("sync_drop", coil_out, 4'b0000);
        ph(300, 1'b1); ph(350, 1'b1); ph(450, 1'b1);
        check("resync_no_dwell", coil_out, 4'b0000);
        ph(7100, 1'b1); ph(50, 1'b1);
        check("resync_wait", coil_out, 4'b0000);
        ph(150, 1'b1);
        check("resync_dwell", coil_out, 4'b0010);

        // Rewrite during dwell, then reset mid-dwell
        eng_phase = 16'd200;
        wr(1, 1'b1, 1000, 2000);
        check("rewrite_abort", coil_out, 4'b0000);
        ph(1100, 1'b1);
        check("rewrite_new_start", coil_out, 4'b0010);
        ph(2100, 1'b1);
        check("rewrite_new_end", coil_out, 4'b0000);
        ph(1500, 1'b1);
        check("redwell", coil_out, 4'b0010);
        rst_n = 1'b0;
        tick();
        check("rst_mid_coil", coil_out, 4'b0000);
        check("rst_mid_fault", fault, 4'b0000);
        rst_n = 1'b1;

        // Randomized run against the reference model
        p = 0;
        for (int k = 0; k < 4000; k++) begin
            rst_n  = ($urandom_range(0, 599) != 0);
            synced = ($urandom_range(0, 39) != 0);
            r = $urandom_range(0, 99);
            if (r < 3) begin
                p = $urandom_range(0, PM - 1);
            end else if (r >= 30) begin
                p = (p + $urandom_range(1, 160)) % PM;
            end
            eng_phase = 16'(p);
            cfg_we = ($urandom_range(0, 24) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_en = ($urandom_range(0, 3) != 0);
            cfg_start = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(PM, 65535))
                                                     : 16'($urandom_range(0, PM - 1));
            cfg_end   = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(PM, 65535))
                                                     : 16'($urandom_range(0, PM - 1));
            if ($urandom_range(0, 9) == 0) cfg_end = cfg_start;
            tick();
            check("rand_coil", coil_out, m_coil);
            check("rand_fault", fault, m_fault);
            check("rand_err", cfg_err, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
